seq_detect_fsm: RTL and testbench

SEQ_DETECT_FSM -- requirements
Module: seq_detect_fsm

---
 rtl/seq_det_pkg.sv | 22 ++
 rtl/sat_counter.sv | 19 +
 rtl/seq_detect_fsm.sv | 82 ++++++++
 tb/tb_seq_detect_fsm.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared state encodings and parameter bounds for the sequence detector
package seq_det_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_t;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;
  localparam int CNT_W_MIN = 1;
  localparam int CNT_W_MAX = 16;

  // Occupancy of the shift register maps directly onto the FSM state.
  function automatic state_t state_of(input int fc, input int full);
    if (fc == 0) return EMPTY;
    else if (fc >= full) return ARMED;
    else return FILL;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - W-bit up counter that sticks at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_fsm.sv
// rtl/seq_detect_fsm.sv - serial pattern detector with fill-tracking FSM and optional match counter
// Define SEQ_DET_CNT_EN to build the saturating match counter; otherwise match_cnt is tied to zero.
module seq_detect_fsm
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             i,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             j,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  localparam int FC_W = $clog2(PAT_W + 1);

  state_t           state, state_nxt;
  logic [PAT_W-1:0] sr, sr_nxt, sr_post, pattern_q;
  logic [FC_W-1:0]  fc, fc_nxt;
  logic             j_nxt, pat_chg, hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      sr        <= '0;
      fc        <= '0;
      pattern_q <= '0;
      j         <= 1'b0;
    end else begin
      state     <= state_nxt;
      sr        <= sr_nxt;
      fc        <= fc_nxt;
      pattern_q <= pattern;
      j         <= j_nxt;
    end
  end

  always_comb begin
    sr_nxt  = sr;
    fc_nxt  = fc;
    sr_post = {sr[PAT_W-2:0], i};
    pat_chg = (pattern != pattern_q);
    // The completing bit only counts once PAT_W-1 valid bits are already held.
    hit     = en && !pat_chg && (fc >= FC_W'(PAT_W - 1)) && (sr_post == pattern_q);
    j_nxt   = hit;

    if (en) begin
      sr_nxt = sr_post;
    end

    if (pat_chg) begin
      fc_nxt = '0;
    end else if (en) begin
      if (hit && !overlap) begin
        fc_nxt = '0;
      end else if (fc != FC_W'(PAT_W)) begin
        fc_nxt = fc + 1'b1;
      end
    end

    state_nxt = state_of(int'(fc_nxt), PAT_W);
  end

  assign armed = (state == ARMED);

`ifdef SEQ_DET_CNT_EN
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (j_nxt),
    .q   (match_cnt)
  );
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_fsm.sv
// tb/tb_seq_detect_fsm.sv - scoreboard bench for seq_detect_fsm (PAT_W=4 main instance, PAT_W=2/CNT_W=2 saturation instance)
module tb_seq_detect_fsm;

`ifdef SEQ_DET_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, i = 1'b0, overlap = 1'b1;
  logic [3:0] pattern = 4'b1011;
  logic       j, armed;
  logic [7:0] match_cnt;

  logic       en2 = 1'b0, i2 = 1'b0, overlap2 = 1'b1;
  logic [1:0] pattern2 = 2'b11;
  logic       j2, armed2;
  logic [1:0] match_cnt2;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] m_sr, m_pq;
  int         m_fc, m_cnt;

  bit exp_j_q[$], exp_a_q[$], obs_j_q[$], obs_a_q[$];
  int exp_c_q[$], obs_c_q[$];

  always #5 clk = ~clk;

  seq_detect_fsm #(.PAT_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .i(i), .pattern(pattern), .overlap(overlap),
    .j(j), .match_cnt(match_cnt), .armed(armed)
  );

  seq_detect_fsm #(.PAT_W(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .i(i2), .pattern(pattern2), .overlap(overlap2),
    .j(j2), .match_cnt(match_cnt2), .armed(armed2)
  );

  // Bench model of one clock edge; expectations are queued before the edge.
  task automatic step(input logic e, input logic b);
    logic       chg, mt;
    logic [3:0] post;
    en   = e;
    i    = b;
    chg  = (pattern != m_pq);
    post = {m_sr[2:0], b};
    mt   = e && !chg && (m_fc >= 3) && (post == m_pq);
    if (e) m_sr = post;
    if (chg) m_fc = 0;
    else if (e) begin
      if (mt && !overlap) m_fc = 0;
      else if (m_fc < 4) m_fc = m_fc + 1;
    end
    m_pq = pattern;
    if (mt && m_cnt < 255) m_cnt = m_cnt + 1;
    exp_j_q.push_back(mt);
    exp_a_q.push_back(m_fc == 4);
    exp_c_q.push_back(CNT_ON ? m_cnt : 0);
    @(posedge clk); #1;
    obs_j_q.push_back(j);
    obs_a_q.push_back(armed);
    obs_c_q.push_back(int'(match_cnt));
  endtask

  task automatic do_reset();
    en = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    m_sr = '0; m_fc = 0; m_pq = '0; m_cnt = 0;
    @(posedge clk); #1;
    m_pq = pattern;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_cmp++; if (j !== 1'b0) begin n_err++; $display("FAIL reset_j: got %b want 0", j); end
    n_cmp++; if (armed !== 1'b0) begin n_err++; $display("FAIL reset_armed: got %b want 0", armed); end
    n_cmp++; if (match_cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", match_cnt); end
    do_reset();
  endtask

  task automatic test_overlap();
    logic [6:0] pulses = '0;
    bit b[7] = '{1, 0, 1, 1, 0, 1, 1};
    int k = 0;
    pattern = 4'b1011; overlap = 1'b1;
    do_reset();
    foreach (b[n]) step(1'b1, b[n]);
    while (exp_j_q.size() > 0) begin
      bit ej, oj, ea, oa; int ec, oc;
      ej = exp_j_q.pop_front(); oj = obs_j_q.pop_front();
      ea = exp_a_q.pop_front(); oa = obs_a_q.pop_front();
      ec = exp_c_q.pop_front(); oc = obs_c_q.pop_front();
      n_cmp++; if (oj !== ej) begin n_err++; $display("FAIL overlap_j[%0d]: got %b want %b", k, oj, ej); end
      n_cmp++; if (oa !== ea) begin n_err++; $display("FAIL overlap_armed[%0d]: got %b want %b", k, oa, ea); end
      n_cmp++; if (oc !== ec) begin n_err++; $display("FAIL overlap_cnt[%0d]: got %0d want %0d", k, oc, ec); end
      pulses = {pulses[5:0], oj};
      k++;
    end
    n_cmp++; if (pulses !== 7'b0001001) begin n_err++; $display("FAIL overlap_pulses: got %b want 0001001", pulses); end
    n_cmp++; if (match_cnt !== (CNT_ON ? 8'd2 : 8'd0)) begin n_err++; $display("FAIL overlap_total: got %0d want %0d", match_cnt, CNT_ON ? 2 : 0); end
  endtask

  task automatic test_no_overlap();
    logic [6:0] pulses = '0;
    bit b[7] = '{1, 0, 1, 1, 0, 1, 1};
    int k = 0;
    pattern = 4'b1011; overlap = 1'b0;
    do_reset();
    foreach (b[n]) step(1'b1, b[n]);
    while (exp_j_q.size() > 0) begin
      bit ej, oj, ea, oa; int ec, oc;
      ej = exp_j_q.pop_front(); oj = obs_j_q.pop_front();
      ea = exp_a_q.pop_front(); oa = obs_a_q.pop_front();
      ec = exp_c_q.pop_front(); oc = obs_c_q.pop_front();
      n_cmp++; if (oj !== ej) begin n_err++; $display("FAIL nooverlap_j[%0d]: got %b want %b", k, oj, ej); end
      n_cmp++; if (oa !== ea) begin n_err++; $display("FAIL nooverlap_armed[%0d]: got %b want %b", k, oa, ea); end
      n_cmp++; if (oc !== ec) begin n_err++; $display("FAIL nooverlap_cnt[%0d]: got %0d want %0d", k, oc, ec); end
      pulses = {pulses[5:0], oj};
      k++;
    end
    n_cmp++; if (pulses !== 7'b0001000) begin n_err++; $display("FAIL nooverlap_pulses: got %b want 0001000", pulses); end
    n_cmp++; if (armed !== 1'b0) begin n_err++; $display("FAIL nooverlap_fill: got armed=%b want 0", armed); end
    n_cmp++; if (match_cnt !== (CNT_ON ? 8'd1 : 8'd0)) begin n_err++; $display("FAIL nooverlap_total: got %0d want %0d", match_cnt, CNT_ON ? 1 : 0); end
  endtask

  task automatic test_en_gap();
    logic [6:0] pulses = '0;
    int k = 0;
    pattern = 4'b1011; overlap = 1'b1;
    do_reset();
    step(1'b1, 1'b1); step(1'b1, 1'b0);
    step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b0);
    step(1'b1, 1'b1); step(1'b1, 1'b1);
    while (exp_j_q.size() > 0) begin
      bit ej, oj, ea, oa; int ec, oc;
      ej = exp_j_q.pop_front(); oj = obs_j_q.pop_front();
      ea = exp_a_q.pop_front(); oa = obs_a_q.pop_front();
      ec = exp_c_q.pop_front(); oc = obs_c_q.pop_front();
      n_cmp++; if (oj !== ej) begin n_err++; $display("FAIL engap_j[%0d]: got %b want %b", k, oj, ej); end
      n_cmp++; if (oa !== ea) begin n_err++; $display("FAIL engap_armed[%0d]: got %b want %b", k, oa, ea); end
      n_cmp++; if (oc !== ec) begin n_err++; $display("FAIL engap_cnt[%0d]: got %0d want %0d", k, oc, ec); end
      pulses = {pulses[5:0], oj};
      k++;
    end
    n_cmp++; if (pulses !== 7'b0000001) begin n_err++; $display("FAIL engap_pulses: got %b want 0000001", pulses); end
    step(1'b0, 1'b1);
    void'(exp_j_q.pop_front()); void'(exp_a_q.pop_front()); void'(exp_c_q.pop_front());
    void'(obs_a_q.pop_front()); void'(obs_c_q.pop_front());
    n_cmp++; if (obs_j_q.pop_front() !== 1'b0) begin n_err++; $display("FAIL engap_drop: got j=1 want 0"); end
  endtask

  task automatic test_async_reset();
    int k = 0;
    pattern = 4'b1011; overlap = 1'b1;
    do_reset();
    step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b1);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (j !== 1'b0) begin n_err++; $display("FAIL areset_j: got %b want 0", j); end
    n_cmp++; if (armed !== 1'b0) begin n_err++; $display("FAIL areset_armed: got %b want 0", armed); end
    n_cmp++; if (match_cnt !== 8'd0) begin n_err++; $display("FAIL areset_cnt: got %0d want 0", match_cnt); end
    @(posedge clk); #1;
    rst = 1'b1;
    m_sr = '0; m_fc = 0; m_pq = '0; m_cnt = 0;
    step(1'b1, 1'b1);
    while (exp_j_q.size() > 0) begin
      bit ej, oj, ea, oa; int ec, oc;
      ej = exp_j_q.pop_front(); oj = obs_j_q.pop_front();
      ea = exp_a_q.pop_front(); oa = obs_a_q.pop_front();
      ec = exp_c_q.pop_front(); oc = obs_c_q.pop_front();
      n_cmp++; if (oj !== ej) begin n_err++; $display("FAIL areset_seq_j[%0d]: got %b want %b", k, oj, ej); end
      n_cmp++; if (oa !== ea) begin n_err++; $display("FAIL areset_seq_armed[%0d]: got %b want %b", k, oa, ea); end
      n_cmp++; if (oc !== ec) begin n_err++; $display("FAIL areset_seq_cnt[%0d]: got %0d want %0d", k, oc, ec); end
      k++;
    end
  endtask

  task automatic test_pattern_change();
    bit b[11] = '{1, 0, 1, 1, 1, 1, 0, 0, 0, 1, 1};
    int k = 0;
    pattern = 4'b1011; overlap = 1'b1;
    do_reset();
    for (int n = 0; n < 11; n++) begin
      if (n == 4) pattern = 4'b0110;
      step(1'b1, b[n]);
    end
    step(1'b1, 1'b0);
    while (exp_j_q.size() > 0) begin
      bit ej, oj, ea, oa; int ec, oc;
      ej = exp_j_q.pop_front(); oj = obs_j_q.pop_front();
      ea = exp_a_q.pop_front(); oa = obs_a_q.pop_front();
      ec = exp_c_q.pop_front(); oc = obs_c_q.pop_front();
      n_cmp++; if (oj !== ej) begin n_err++; $display("FAIL patchg_j[%0d]: got %b want %b", k, oj, ej); end
      n_cmp++; if (oa !== ea) begin n_err++; $display("FAIL patchg_armed[%0d]: got %b want %b", k, oa, ea); end
      n_cmp++; if (oc !== ec) begin n_err++; $display("FAIL patchg_cnt[%0d]: got %0d want %0d", k, oc, ec); end
      if (k == 4 || k == 11) begin
        n_cmp++;
        if (oj !== (k == 11)) begin n_err++; $display("FAIL patchg_point[%0d]: got %b want %b", k, oj, k == 11); end
      end
      k++;
    end
  endtask

  task automatic test_overlap_switch();
    bit b[7] = '{1, 0, 1, 1, 0, 1, 1};
    int k = 0;
    pattern = 4'b1011; overlap = 1'b1;
    do_reset();
    for (int n = 0; n < 7; n++) begin
      if (n == 4) overlap = 1'b0;
      step(1'b1, b[n]);
    end
    step(1'b1, 1'b1);
    while (exp_j_q.size() > 0) begin
      bit ej, oj, ea, oa; int ec, oc;
      ej = exp_j_q.pop_front(); oj = obs_j_q.pop_front();
      ea = exp_a_q.pop_front(); oa = obs_a_q.pop_front();
      ec = exp_c_q.pop_front(); oc = obs_c_q.pop_front();
      n_cmp++; if (oj !== ej) begin n_err++; $display("FAIL ovswitch_j[%0d]: got %b want %b", k, oj, ej); end
      n_cmp++; if (oa !== ea) begin n_err++; $display("FAIL ovswitch_armed[%0d]: got %b want %b", k, oa, ea); end
      n_cmp++; if (oc !== ec) begin n_err++; $display("FAIL ovswitch_cnt[%0d]: got %0d want %0d", k, oc, ec); end
      k++;
    end
  endtask

  task automatic test_saturate();
    int cnt_exp;
    en2 = 1'b0;
    @(posedge clk); #1;
    for (int k = 1; k <= 8; k++) begin
      en2 = 1'b1; i2 = 1'b1;
      @(posedge clk); #1;
      cnt_exp = CNT_ON ? ((k - 1) > 3 ? 3 : (k - 1)) : 0;
      n_cmp++; if (j2 !== (k >= 2)) begin n_err++; $display("FAIL sat_j[%0d]: got %b want %b", k, j2, k >= 2); end
      n_cmp++; if (armed2 !== (k >= 2)) begin n_err++; $display("FAIL sat_armed[%0d]: got %b want %b", k, armed2, k >= 2); end
      n_cmp++; if (int'(match_cnt2) !== cnt_exp) begin n_err++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", k, match_cnt2, cnt_exp); end
    end
    en2 = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (j2 !== 1'b0) begin n_err++; $display("FAIL sat_drop: got %b want 0", j2); end
  endtask

  initial begin
    m_sr = '0; m_fc = 0; m_pq = '0; m_cnt = 0;
    test_reset();
    test_overlap();
    test_no_overlap();
    test_en_gap();
    test_async_reset();
    test_pattern_change();
    test_overlap_switch();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
